// File: rtl/spi_ram_pkg.sv
// Shared opcodes, FSM state encoding and opcode classes for the SPI serial-SRAM responder.
package spi_ram_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_WRITE     = 8'h02;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD,
    ST_WR,
    ST_IGNORE
  } ram_state_e;

  typedef enum logic [1:0] {
    OPK_READ,
    OPK_WRITE,
    OPK_FAST
  } op_kind_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for the SPI pins, with SCLK rise/fall strobes taken from the
// last two synchronized SCLK samples.
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_n,
  input  logic sclk,
  input  logic mosi,
  output logic cs_n_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic cs_meta;
  logic sclk_meta;
  logic sclk_s;
  logic sclk_d;
  logic mosi_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta   <= 1'b1;
      cs_n_s    <= 1'b1;
      sclk_meta <= 1'b0;
      sclk_s    <= 1'b0;
      sclk_d    <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      cs_meta   <= cs_n;
      cs_n_s    <= cs_meta;
      sclk_meta <= sclk;
      sclk_s    <= sclk_meta;
      sclk_d    <= sclk_s;
      mosi_meta <= mosi;
      mosi_s    <= mosi_meta;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 serial-SRAM target (READ 0x03 / WRITE 0x02) oversampled in the clk domain.
// Define SPI_RAM_FAST_READ_EN to accept FAST READ (0x0B) with 8 dummy clocks.
module spi_ram_responder
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned ADDR_BITS = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_cs_n,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic busy,
  output logic cmd_err
);

  logic cs_n_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;

  spi_pin_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_n      (spi_cs_n),
    .sclk      (spi_sclk),
    .mosi      (spi_mosi),
    .cs_n_s    (cs_n_s),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  ram_state_e           state_q, state_d;
  op_kind_e             op_q, op_d;
  logic                 cmd_err_q, cmd_err_d;
  logic [2:0]           bit_cnt_q;
  logic [1:0]           addr_byte_q;
  logic [6:0]           sh_q;
  logic [7:0]           tx_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 miso_q;
  logic [7:0]           mem [MEM_BYTES];

  logic                 rise_en;
  logic                 fall_en;
  logic                 byte_done;
  logic [7:0]           rx_byte;
  logic [ADDR_BITS-1:0] addr_shifted;
  logic [ADDR_BITS-1:0] addr_inc;
  logic                 load_tx;
  logic [ADDR_BITS-1:0] tx_addr;
  logic                 wr_en;

  // SCLK edges seen while synchronized CS is high are dropped here.
  assign rise_en      = sclk_rise & ~cs_n_s;
  assign fall_en      = sclk_fall & ~cs_n_s;
  assign byte_done    = rise_en & (bit_cnt_q == 3'd7);
  assign rx_byte      = {sh_q, mosi_s};
  assign addr_shifted = {addr_q[ADDR_BITS-2:0], mosi_s};
  assign addr_inc     = addr_q + ADDR_BITS'(1);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cmd_err_d = 1'b0;
    load_tx   = 1'b0;
    tx_addr   = addr_q;
    wr_en     = 1'b0;
    if (cs_n_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            case (rx_byte)
              OP_READ: begin
                op_d    = OPK_READ;
                state_d = ST_ADDR;
              end
              OP_WRITE: begin
                op_d    = OPK_WRITE;
                state_d = ST_ADDR;
              end
              OP_FAST_READ: begin
`ifdef SPI_RAM_FAST_READ_EN
                op_d    = OPK_FAST;
                state_d = ST_ADDR;
`else
                cmd_err_d = 1'b1;
                state_d   = ST_IGNORE;
`endif
              end
              default: begin
                cmd_err_d = 1'b1;
                state_d   = ST_IGNORE;
              end
            endcase
          end
        end
        ST_ADDR: begin
          if (byte_done && (addr_byte_q == 2'd2)) begin
            case (op_q)
              OPK_WRITE: state_d = ST_WR;
              OPK_FAST:  state_d = ST_DUMMY;
              default: begin
                state_d = ST_RD;
                load_tx = 1'b1;
                tx_addr = addr_shifted;
              end
            endcase
          end
        end
        ST_DUMMY: begin
          if (byte_done) begin
            state_d = ST_RD;
            load_tx = 1'b1;
          end
        end
        // Prefetch at the byte boundary; the next SCLK fall drives its bit 7.
        ST_RD: begin
          if (byte_done) begin
            load_tx = 1'b1;
            tx_addr = addr_inc;
          end
        end
        ST_WR: wr_en = byte_done;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OPK_READ;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      addr_byte_q <= '0;
      sh_q        <= '0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        bit_cnt_q   <= '0;
        addr_byte_q <= '0;
        sh_q        <= '0;
        addr_q      <= '0;
      end else if (rise_en) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        sh_q      <= rx_byte[6:0];
        if (state_q == ST_ADDR) begin
          addr_q <= addr_shifted;
          if (byte_done) addr_byte_q <= addr_byte_q + 2'd1;
        end
        if (byte_done && (state_q == ST_RD || state_q == ST_WR)) addr_q <= addr_inc;
      end
      if (state_q != ST_RD) begin
        miso_q <= 1'b0;
      end else if (fall_en) begin
        miso_q <= tx_q[~bit_cnt_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr_q] <= rx_byte;
    if (load_tx) tx_q <= mem[tx_addr];
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = (state_q == ST_RD);
  assign busy        = ~cs_n_s;
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: write/read, wrap, alias, abort, bad opcode, reset, fast read.
`timescale 1ns/1ps
module tb_spi_ram_responder;

  localparam int HALF = 6;

  logic clk;
  logic rst_n;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;
  logic busy;
  logic cmd_err;

  spi_ram_responder #(
    .MEM_BYTES (8192),
    .ADDR_BITS (13)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_cs_n    (spi_cs_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .busy        (busy),
    .cmd_err     (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_pulses   = 0;
  int drive_cycles = 0;

  always @(negedge clk) begin
    if (cmd_err) err_pulses++;
    if (spi_miso || spi_miso_oe) drive_cycles++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  task check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx, output logic [7:0] oe);
    rx = '0;
    oe = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = spi_miso;
      oe[i] = spi_miso_oe;
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task txn_hdr(input logic [7:0] op, input logic [23:0] addr, output logic [7:0] oe_or);
    logic [7:0] rx, oe;
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer(op, 8, rx, oe);            oe_or = oe;
    xfer(addr[23:16], 8, rx, oe);   oe_or |= oe;
    xfer(addr[15:8], 8, rx, oe);    oe_or |= oe;
    xfer(addr[7:0], 8, rx, oe);     oe_or |= oe;
  endtask

  task txn_end();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task do_write(input logic [23:0] addr, input int n, input logic [23:0] data);
    logic [7:0] rx, oe, oh;
    txn_hdr(8'h02, addr, oh);
    for (int k = 0; k < n; k++) xfer(data[23-8*k -: 8], 8, rx, oe);
    txn_end();
  endtask

  task do_read(input logic [7:0] op, input logic [23:0] addr, input int n,
               output logic [23:0] data, output logic [7:0] oe_hdr, output logic [7:0] oe_dat);
    logic [7:0] rx, oe;
    data   = '0;
    oe_dat = '1;
    txn_hdr(op, addr, oe_hdr);
    for (int k = 0; k < n; k++) begin
      xfer(8'h00, 8, rx, oe);
      data[23-8*k -: 8] = rx;
      oe_dat &= oe;
    end
    txn_end();
  endtask

  logic [23:0] d;
  logic [7:0]  oh, od, rx, oe;
  int          e0, dc0;

  initial begin
    rst_n    = 1'b0;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_miso", spi_miso, 0);
    check_eq("rst_oe", spi_miso_oe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cmd_err", cmd_err, 0);

    // Write then read back two bytes
    do_write(24'h000010, 2, 24'hDEAD00);
    do_read(8'h03, 24'h000010, 2, d, oh, od);
    check_eq("rd10_b0", d[23:16], 8'hDE);
    check_eq("rd10_b1", d[15:8], 8'hAD);
    check_eq("rd10_oe_hdr", oh, 8'h00);
    check_eq("rd10_oe_data", od, 8'hFF);
    check_eq("good_txn_no_err", err_pulses, 0);

    // Address wrap at top of array
    do_write(24'h001FFF, 3, 24'h112233);
    do_read(8'h03, 24'h001FFF, 3, d, oh, od);
    check_eq("wrap_b0", d[23:16], 8'h11);
    check_eq("wrap_b1", d[15:8], 8'h22);
    check_eq("wrap_b2", d[7:0], 8'h33);
    do_read(8'h03, 24'h000000, 2, d, oh, od);
    check_eq("mem0", d[23:16], 8'h22);
    check_eq("mem1", d[15:8], 8'h33);

    // Upper address bits alias onto the array
    do_read(8'h03, 24'hFFE010, 1, d, oh, od);
    check_eq("alias_FFE010", d[23:16], 8'hDE);

    // Aborted write: partial second byte discarded
    do_write(24'h000021, 1, 24'h5A0000);
    txn_hdr(8'h02, 24'h000020, oh);
    xfer(8'hA5, 8, rx, oe);
    xfer(8'hFF, 4, rx, oe);
    txn_end();
    do_read(8'h03, 24'h000020, 2, d, oh, od);
    check_eq("abort_mem20", d[23:16], 8'hA5);
    check_eq("abort_mem21", d[15:8], 8'h5A);

    // Unsupported opcode
    e0  = err_pulses;
    dc0 = drive_cycles;
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer(8'h9F, 8, rx, oe);
    repeat (4) @(negedge clk);
    check_eq("bad_op_err_pulse", err_pulses - e0, 1);
    for (int k = 0; k < 4; k++) xfer(8'hFF, 8, rx, oe);
    repeat (HALF) @(negedge clk);
    check_eq("bad_op_no_drive", drive_cycles - dc0, 0);
    check_eq("bad_op_busy", busy, 1);
    spi_cs_n = 1'b1;
    @(negedge clk);
    check_eq("busy_lag1", busy, 1);
    @(negedge clk);
    check_eq("busy_lag2", busy, 0);
    repeat (2 * HALF) @(negedge clk);

    // Reset during the data phase of a READ
    txn_hdr(8'h03, 24'h000010, oh);
    xfer(8'h00, 4, rx, oe);
    check_eq("pre_rst_oe", spi_miso_oe, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_miso", spi_miso, 0);
    check_eq("mid_rst_oe", spi_miso_oe, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_cmd_err", cmd_err, 0);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_read(8'h03, 24'h000010, 1, d, oh, od);
    check_eq("post_rst_rd10", d[23:16], 8'hDE);

`ifdef SPI_RAM_FAST_READ_EN
    txn_hdr(8'h0B, 24'h000010, oh);
    xfer(8'h00, 8, rx, oe);
    oh |= oe;
    xfer(8'h00, 8, rx, oe);
    d[23:16] = rx;
    xfer(8'h00, 8, rx, oe);
    d[15:8] = rx;
    txn_end();
    check_eq("fast_b0", d[23:16], 8'hDE);
    check_eq("fast_b1", d[15:8], 8'hAD);
    check_eq("fast_oe_hdr_dummy", oh, 8'h00);
`else
    e0 = err_pulses;
    txn_hdr(8'h0B, 24'h000010, oh);
    txn_end();
    check_eq("fast_op_err_pulse", err_pulses - e0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
